// File: rtl/riscv_lsu_if.sv
// Bundle of the LSU core-request, core-response, memory and observation-tap signals.
// The slave modport is the LSU view; master is the core/memory environment view.
interface riscv_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  localparam int NB = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [1:0]        resp_err;

  logic              mem_req;
  logic              mem_we;
  logic [NB-1:0]     mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic              wr;
  logic              rd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
  // memory completes on a rising edge where mem_req && mem_ready; resp_valid is a
  // single-cycle pulse with no backpressure.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output wr, rd, addr, wr_data, rd_data
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  wr, rd, addr, wr_data, rd_data
  );
endinterface

// File: rtl/riscv_lsu.sv
// RISC-V load/store unit: sizes, aligns and sign-extends loads/stores and runs a
// req/ready memory handshake with wait states and an optional timeout.
module riscv_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  riscv_lsu_if.slave       bus,
  output logic [1:0]       dbg_state_o
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2} state_e;

  state_e            state_q;
  logic              we_q, uns_q;
  logic [1:0]        sz_q;
  logic [OB-1:0]     off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sized_q;
  logic [CW-1:0]     cnt_q;

  logic              req_ready_q, resp_valid_q, mem_req_q, mem_we_q, wr_q, rd_q;
  logic [DATA_W-1:0] resp_data_q, mem_wdata_q, wr_data_q, rd_data_q;
  logic [1:0]        resp_err_q;
  logic [NB-1:0]     mem_be_q;
  logic [ADDR_W-1:0] mem_addr_q, tap_addr_q;

  logic [1:0]        sz_d;
  logic              illegal_d, misal_d;
  logic [7:0]        mask8;
  logic [NB-1:0]     be_d;
  logic [DATA_W-1:0] rep_d, sized_d;

  // Request decode: size, legality, alignment, byte enables and lane replication.
  always_comb begin
    sz_d      = bus.req_funct3[1:0];
    illegal_d = (bus.req_funct3 == 3'b111) || (bus.req_funct3[2] && bus.req_we) ||
                ((DATA_W == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)));
    case (sz_d)
      2'd0: begin misal_d = 1'b0;                  mask8 = 8'h01; rep_d = {NB{bus.req_wdata[7:0]}}; end
      2'd1: begin misal_d = bus.req_addr[0];       mask8 = 8'h03; rep_d = {(NB/2){bus.req_wdata[15:0]}}; end
      2'd2: begin misal_d = |bus.req_addr[1:0];    mask8 = 8'h0F; rep_d = {(NB/4){bus.req_wdata[31:0]}}; end
      default: begin misal_d = |bus.req_addr[2:0]; mask8 = 8'hFF; rep_d = bus.req_wdata; end
    endcase
    be_d = mask8[NB-1:0] << bus.req_addr[OB-1:0];
    sized_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (mask8[i]) sized_d[8*i +: 8] = bus.req_wdata[8*i +: 8];
    end
  end

  logic [DATA_W-1:0] shifted, ld_data;

  always_comb begin
    shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (sz_q)
      2'd0:    ld_data = uns_q ? DATA_W'(shifted[7:0])  : DATA_W'($signed(shifted[7:0]));
      2'd1:    ld_data = uns_q ? DATA_W'(shifted[15:0]) : DATA_W'($signed(shifted[15:0]));
      2'd2:    ld_data = uns_q ? DATA_W'(shifted[31:0]) : DATA_W'($signed(shifted[31:0]));
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      uns_q        <= 1'b0;
      sz_q         <= '0;
      off_q        <= '0;
      addr_q       <= '0;
      sized_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      tap_addr_q   <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            uns_q       <= bus.req_funct3[2];
            sz_q        <= sz_d;
            off_q       <= bus.req_addr[OB-1:0];
            addr_q      <= bus.req_addr[ADDR_W-1:0];
            sized_q     <= sized_d;
            if (illegal_d || misal_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_data_q  <= '0;
              resp_err_q   <= illegal_d ? 2'b11 : 2'b01;
            end else begin
              state_q     <= S_ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_be_q    <= be_d;
              mem_addr_q  <= {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
              mem_wdata_q <= rep_d;
              cnt_q       <= CW'(1);
            end
          end
        end
        S_ACCESS: begin
          // Ready wins over timeout when both occur in the same cycle.
          if (bus.mem_ready) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 2'b00;
            resp_data_q  <= we_q ? '0 : ld_data;
            wr_q         <= we_q;
            rd_q         <= !we_q;
            tap_addr_q   <= addr_q;
            if (we_q) wr_data_q <= sized_q;
            else      rd_data_q <= ld_data;
          end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT))) begin
            state_q      <= S_RESP;
            mem_req_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 2'b10;
            resp_data_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.wr         = wr_q;
  assign bus.rd         = rd_q;
  assign bus.addr       = tap_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.rd_data    = rd_data_q;
  assign dbg_state_o    = state_q;
endmodule
